serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Parallel-to-serial frame transmitter that produces the single-bit `d` stream consumed by the team's D flip-flop capture chain. A WIDTH-bit word is accepted through a valid/ready handshake and shifted out LSB-first in a framed sequence: start bit, data bits, even-parity bit, stop bit. Each bit is held for DIV clocks. The block is the driving end of the serial link; the flip-flop/shift chain is the receiving end.

## Interface

Parameters:
- `WIDTH`, default 8: data bits per frame, ≥1.
- `DIV`, default 4: clocks per serial bit, ≥1.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `reset`  input  1: synchronous reset, active-low.
- `data_in`  input  WIDTH: word to send; sampled only on acceptance.
- `valid`  input  1: `data_in` is available.
- `ready`  output  1: block can accept a word.
- `d`  output  1: serial line, registered; idle level 1.
- `busy`  output  1: frame in progress (state ≠ IDLE).
- `done`  output  1: one-cycle pulse after the stop bit completes.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Reset (`reset`=0 at a clock edge):
  - state = IDLE, `d`=1, `busy`=0, `done`=0, bit timer = 0, bit index = 0.
  - `ready` is forced 0 combinationally while `reset`=0, and `valid` is ignored.
  - Reset mid-frame aborts the frame immediately with no partial `done`.
- `ready` = (state == IDLE) and `reset`=1.
- Acceptance: an edge where `valid`=1 and `ready`=1.
  - Captures `data_in` into the shift register.
  - Computes parity = XOR-reduction of the captured word (even parity).
  - Moves to START.
  - Later changes to `data_in` or `valid` have no effect until the next acceptance.
- START: `d`=0 for DIV clocks, then DATA.
- DATA: `d` = shift register bit 0, held DIV clocks per bit. After each bit the register shifts right. After WIDTH bits, go to PARITY.
- PARITY: `d` = parity, held DIV clocks, then STOP.
- STOP: `d`=1, held DIV clocks, then IDLE with `done`=1 for exactly that first IDLE cycle.
- Bit timer:
  - Loads DIV-1 on entry to each bit and decrements every clock.
  - The bit ends on the cycle the timer equals 0.
  - With DIV=1, every bit lasts one clock.
- Bit index counts 0..WIDTH-1 and is sized to hold WIDTH-1.
- `valid`=1 in any non-IDLE state is ignored; no queuing.

## Timing

- Accept at edge T0.
  - First start-bit cycle is T0+1.
  - Frame occupies cycles T0+1 … T0+(WIDTH+3)·DIV.
  - `done`=1 and `ready`=1 at cycle T0+(WIDTH+3)·DIV+1.
- Back-to-back: `valid` held high. The next word is accepted in the `done` cycle, giving exactly one idle cycle (`d`=1) between a stop bit and the next start bit.
- `busy` goes to 1 at T0+1 and to 0 in the `done` cycle.
- `d` is registered and glitch-free. It changes only at bit boundaries and never changes during a bit's DIV clocks.
- Reset asserted during any state: at the next edge, `d`=1 and `busy`=0. `ready`=1 on the first edge with `reset`=1. A word presented in that same cycle is accepted.

## Test plan

- Reset values:
  - Hold `reset`=0 for 3 clocks with `valid`=1 → `d`=1, `busy`=0, `done`=0, `ready`=0 throughout.
  - After release → `ready`=1.
- Single frame (WIDTH=8, DIV=4), send 0xA5 at T0:
  - `d`=0 for T0+1..4.
  - Data bits 1,0,1,0,0,1,0,1, each 4 clocks (T0+5..36).
  - Parity 0 (T0+37..40), stop 1 (T0+41..44).
  - `done`=`ready`=1 at T0+45.
- Parity check: send 0x07 → parity bit = 1; send 0x00 → parity bit = 0 and all data bits 0.
- Back-to-back: `valid` held high with 0x3C then 0xC3 → second accepted at T0+45, `d`=1 only at T0+45, second start bit at T0+46. Change `data_in` mid-frame → transmitted bits unaffected.
- Reset mid-frame: assert `reset`=0 during DATA bit 3 → next edge `d`=1, `busy`=0, no `done` pulse. After release, 0x5A sends a complete, correct frame.
- DIV=1, WIDTH=4: send 0xB → `d` sequence 0,1,1,0,1,1(parity),1(stop) on consecutive clocks; `done` at T0+8.

Source files
------------

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx
// Purpose  : Framed LSB-first serial transmitter (start, data, even parity, stop).
// Revision : 1.0
// ============================================================================
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             d,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TMR_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [TMR_W-1:0] c_TMR_LOAD = TMR_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_shift_sr;
    logic             r_parity;
    logic             w_parity_next;
    logic             r_d;
    logic             w_d_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_accept;
    logic             w_bit_end;

    assign ready      = (r_state == S_IDLE) && reset;
    assign w_accept   = valid && ready;
    assign w_bit_end  = (r_timer == '0);
    assign w_shift_sr = r_shift >> 1;

    assign d    = r_d;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_d      <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_d      <= w_d_next;
            r_done   <= w_done_next;
        end
    end

    // Line level is computed one cycle ahead so d is a clean register output.
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_d_next      = r_d;
        w_done_next   = 1'b0;

        if (r_state != S_IDLE) begin
            w_timer_next = w_bit_end ? c_TMR_LOAD : (r_timer - TMR_W'(1));
        end

        case (r_state)
            S_IDLE: begin
                w_d_next = 1'b1;
                if (w_accept) begin
                    w_state_next  = S_START;
                    w_timer_next  = c_TMR_LOAD;
                    w_idx_next    = '0;
                    w_shift_next  = data_in;
                    w_parity_next = ^data_in;
                    w_d_next      = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_d_next     = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = S_PARITY;
                        w_d_next     = r_parity;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_shift_next = w_shift_sr;
                        w_d_next     = w_shift_sr[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_d_next     = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_d_next     = 1'b1;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
                w_idx_next   = '0;
                w_d_next     = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_tx
// Purpose  : Scoreboard bench for serial_word_tx (8/4 and 4/1 configurations).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_serial_word_tx;

    localparam int N8 = 11 * 4;
    localparam int N4 = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       d;
    logic       busy;
    logic       done;
    logic [3:0] data_in1;
    logic       valid1;
    logic       ready1;
    logic       d1;
    logic       busy1;
    logic       done1;

    logic       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(8), .DIV(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .d       (d),
        .busy    (busy),
        .done    (done)
    );

    serial_word_tx #(.WIDTH(4), .DIV(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in1),
        .valid   (valid1),
        .ready   (ready1),
        .d       (d1),
        .busy    (busy1),
        .done    (done1)
    );

    // Expected line level per clock for one frame.
    task automatic push_frame(input logic [7:0] w, input int width, input int div);
        logic par;
        par = 1'b0;
        for (int i = 0; i < width; i++) par = par ^ w[i];
        for (int k = 0; k < div; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < width; i++)
            for (int k = 0; k < div; k++) exp_q.push_back(w[i]);
        for (int k = 0; k < div; k++) exp_q.push_back(par);
        for (int k = 0; k < div; k++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0; valid = 1'b1; data_in = 8'hFF; valid1 = 1'b1; data_in1 = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({d, busy, done, ready} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_state c=%0d: d/busy/done/ready=%b required 1000", c, {d, busy, done, ready});
            end
            n_checks++;
            if ({d1, busy1, done1, ready1} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_state_div1 c=%0d: d/busy/done/ready=%b required 1000", c, {d1, busy1, done1, ready1});
            end
        end
        valid = 1'b0; valid1 = 1'b0; reset = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b ready1=%b required 1 1", ready, ready1);
        end
    endtask

    task automatic test_frame(input logic [7:0] w, input string name);
        logic e;
        @(negedge clk);
        data_in = w; valid = 1'b1;
        push_frame(w, 8, 4);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_before: ready=%b required 1", name, ready);
        end
        @(negedge clk);
        valid = 1'b0; data_in = ~w;
        for (int c = 1; c <= N8; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_bit c=%0d: d=%b busy=%b done=%b required d=%b busy=1 done=0", name, c, d, busy, done, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({d, busy, done, ready} !== 4'b1011) begin
            n_fail++;
            $display("FAIL %s_done: d/busy/done/ready=%b required 1011", name, {d, busy, done, ready});
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        @(negedge clk);
        data_in = 8'h3C; valid = 1'b1;
        push_frame(8'h3C, 8, 4);
        exp_q.push_back(1'b1);
        push_frame(8'hC3, 8, 4);
        @(negedge clk);
        for (int c = 1; c <= 2 * N8 + 1; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e || busy !== (c != N8 + 1)) begin
                n_fail++;
                $display("FAIL b2b_bit c=%0d: d=%b busy=%b required d=%b busy=%b", c, d, busy, e, (c != N8 + 1));
            end
            if (c == N8 + 1) begin
                n_checks++;
                if (done !== 1'b1 || ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gap: done=%b ready=%b required 1 1", done, ready);
                end
            end
            if (c == 5)  data_in = 8'hFF;
            if (c == 20) data_in = 8'hC3;
            if (c == N8 + 2) begin
                valid = 1'b0; data_in = 8'h00;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({d, busy, done, ready} !== 4'b1011) begin
            n_fail++;
            $display("FAIL b2b_done: d/busy/done/ready=%b required 1011", {d, busy, done, ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        @(negedge clk);
        data_in = 8'hFF; valid = 1'b1;
        push_frame(8'hFF, 8, 4);
        @(negedge clk);
        valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL abort_prefix c=%0d: d=%b required %b", c, d, e);
            end
        end
        exp_q.delete();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({d, busy, done, ready} !== 4'b1000) begin
                n_fail++;
                $display("FAIL abort_state c=%0d: d/busy/done/ready=%b required 1000", c, {d, busy, done, ready});
            end
        end
        reset = 1'b1;
        data_in = 8'h5A; valid = 1'b1;
        push_frame(8'h5A, 8, 4);
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release_ready: ready=%b required 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
        for (int c = 1; c <= N8; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL after_abort_bit c=%0d: d=%b busy=%b done=%b required d=%b busy=1 done=0", c, d, busy, done, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({d, busy, done, ready} !== 4'b1011) begin
            n_fail++;
            $display("FAIL after_abort_done: d/busy/done/ready=%b required 1011", {d, busy, done, ready});
        end
    endtask

    task automatic test_div1();
        logic [6:0] seq;
        logic       e;
        seq = 7'b1110110;
        @(negedge clk);
        data_in1 = 4'hB; valid1 = 1'b1;
        for (int i = 0; i < N4; i++) exp_q.push_back(seq[i]);
        @(negedge clk);
        valid1 = 1'b0; data_in1 = 4'h0;
        for (int c = 1; c <= N4; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d1 !== e || busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL div1_bit c=%0d: d=%b busy=%b done=%b required d=%b busy=1 done=0", c, d1, busy1, done1, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({d1, busy1, done1, ready1} !== 4'b1011) begin
            n_fail++;
            $display("FAIL div1_done: d/busy/done/ready=%b required 1011", {d1, busy1, done1, ready1});
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, "single_A5");
        test_frame(8'h07, "parity_07");
        test_frame(8'h00, "parity_00");
        test_back_to_back();
        test_reset_mid_frame();
        test_div1();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
